mem_arbiter: RTL and testbench

Sequences and shares the 8-bit memory module (MAR, write port, read port) among three requesters: the instruction controller, the program loader and the debug/output port. A granted request is turned into the memory's two-step MAR-then-access protocol on the shared 16-bit bus. The result is returned with a one-cycle acknowledge. Grants are round-robin, so no requester starves. The block sits between the requesters and the memory module's `mar_write_en`, `mem_write_en`, `data_in` and `out` pins, and owns the bus whenever `bus_drive` is high.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: round-robin sharing of the 8-bit memory among three requesters,
// turning each grant into the memory's MAR-then-access sequence on the shared bus.
//
// state  | meaning
// IDLE   | no transaction in flight; arbitrates every edge
// ADDR   | latched address on the bus, MAR load enabled
// ACCESS | write data on the bus (write) or memory output enabled (read)
// ACK    | one-cycle ack to the granted requester; arbitrates for the next grant
module mem_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 16,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [AW-1:0]        bus_out,
  output logic                 bus_drive,
  output logic                 mem_mar_write_en,
  output logic                 mem_write_en,
  output logic                 mem_out_en,
  input  logic [DW-1:0]        mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, ACK} state_t;

  state_t          state;
  logic [1:0]      prio;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [1:0]      pick;
  logic [NREQ-1:0] pick_oh;
  logic [2:0]      pos;
  logic [1:0]      slot;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_we;

  // In ACK the acked requester still holds req, so it is masked out via gnt.
  always_comb begin
    elig    = req;
    found   = 1'b0;
    pick    = 2'd0;
    pick_oh = '0;
    pos     = 3'd0;
    slot    = 2'd0;
    if (state == ACK) elig = req & ~gnt;
    for (int k = 0; k < NREQ; k++) begin
      pos = 3'(k) + {1'b0, prio};
      if (pos >= 3'd3) pos = pos - 3'd3;
      slot = pos[1:0];
      if (!found && elig[slot]) begin
        found         = 1'b1;
        pick          = slot;
        pick_oh[slot] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_we = we[pick];
    case (pick)
      2'd1:    begin sel_addr = addr[AW +: AW];   sel_wdata = wdata[DW +: DW];   end
      2'd2:    begin sel_addr = addr[2*AW +: AW]; sel_wdata = wdata[2*DW +: DW]; end
      default: begin sel_addr = addr[0 +: AW];    sel_wdata = wdata[0 +: DW];    end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      prio             <= 2'd0;
      lat_we           <= 1'b0;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      gnt              <= '0;
      ack              <= '0;
      rdata            <= '0;
      busy             <= 1'b0;
      bus_out          <= '0;
      bus_drive        <= 1'b0;
      mem_mar_write_en <= 1'b0;
      mem_write_en     <= 1'b0;
      mem_out_en       <= 1'b0;
    end else begin
      case (state)
        IDLE, ACK: begin
          ack <= '0;
          if (found) begin
            state            <= ADDR;
            prio             <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
            lat_we           <= sel_we;
            lat_addr         <= sel_addr;
            lat_wdata        <= sel_wdata;
            gnt              <= pick_oh;
            busy             <= 1'b1;
            bus_out          <= sel_addr;
            bus_drive        <= 1'b1;
            mem_mar_write_en <= 1'b1;
            mem_write_en     <= 1'b0;
            mem_out_en       <= 1'b0;
          end else begin
            state            <= IDLE;
            gnt              <= '0;
            busy             <= 1'b0;
            bus_out          <= '0;
            bus_drive        <= 1'b0;
            mem_mar_write_en <= 1'b0;
            mem_write_en     <= 1'b0;
            mem_out_en       <= 1'b0;
          end
        end
        ADDR: begin
          state            <= ACCESS;
          mem_mar_write_en <= 1'b0;
          if (lat_we) begin
            bus_out      <= {{(AW-DW){1'b0}}, lat_wdata};
            bus_drive    <= 1'b1;
            mem_write_en <= 1'b1;
            mem_out_en   <= 1'b0;
          end else begin
            bus_out      <= '0;
            bus_drive    <= 1'b0;
            mem_write_en <= 1'b0;
            mem_out_en   <= 1'b1;
          end
        end
        ACCESS: begin
          state        <= ACK;
          ack          <= gnt;
          bus_out      <= '0;
          bus_drive    <= 1'b0;
          mem_write_en <= 1'b0;
          mem_out_en   <= 1'b0;
          if (!lat_we) rdata <= mem_rd_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: directed scenarios against a small bus + MAR + 256-byte memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [47:0] addr = '0;
  logic [23:0] wdata = '0;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [15:0] bus_out;
  logic        bus_drive;
  logic        mem_mar_write_en;
  logic        mem_write_en;
  logic        mem_out_en;
  logic [7:0]  mem_rd_data;

  logic [15:0] bus;
  logic [15:0] mar;
  logic [7:0]  mem [0:255];
  logic        mem_clr = 1'b1;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NREQ(3), .AW(16), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .bus_out(bus_out),
    .bus_drive(bus_drive), .mem_mar_write_en(mem_mar_write_en),
    .mem_write_en(mem_write_en), .mem_out_en(mem_out_en), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  assign bus = bus_drive ? bus_out : (mem_out_en ? {8'h00, mem_rd_data} : 16'h0000);
  assign mem_rd_data = mem[mar[7:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      mar <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      if (mem_mar_write_en) mar <= bus;
      if (mem_write_en) mem[mar[7:0]] <= bus[7:0];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_clr = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) tick;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({bus_out, bus_drive} !== 17'h0) begin errors++; $display("FAIL reset_bus: got %h/%b expected 0000/0", bus_out, bus_drive); end
    checks++; if ({mem_mar_write_en, mem_write_en, mem_out_en} !== 3'b000) begin
      errors++; $display("FAIL reset_en: got %b expected 000", {mem_mar_write_en, mem_write_en, mem_out_en});
    end
    mem_clr = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_write;
    req = 3'b001; we = 3'b001; addr[0 +: 16] = 16'h0010; wdata[0 +: 8] = 8'h5A;
    tick;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wr_gnt: got %b expected 001", gnt); end
    checks++; if (bus_out !== 16'h0010 || bus_drive !== 1'b1 || mem_mar_write_en !== 1'b1) begin
      errors++; $display("FAIL wr_addr_phase: got bus %h drv %b mar %b expected 0010 1 1", bus_out, bus_drive, mem_mar_write_en);
    end
    tick;
    checks++; if (bus_out !== 16'h005A || mem_write_en !== 1'b1 || mem_mar_write_en !== 1'b0) begin
      errors++; $display("FAIL wr_access: got bus %h we %b mar %b expected 005a 1 0", bus_out, mem_write_en, mem_mar_write_en);
    end
    tick;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL wr_ack: got %b expected 001", ack); end
    checks++; if ({mem_mar_write_en, mem_write_en, mem_out_en} !== 3'b000) begin
      errors++; $display("FAIL wr_ack_en: got %b expected 000", {mem_mar_write_en, mem_write_en, mem_out_en});
    end
    req = 3'b000;
    tick;
    checks++; if (ack !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got ack %b busy %b expected 000 0", ack, busy); end
    checks++; if (mem[8'h10] !== 8'h5A) begin errors++; $display("FAIL wr_mem: got %h expected 5a", mem[8'h10]); end
  endtask

  task automatic test_read;
    req = 3'b010; we = 3'b000; addr[16 +: 16] = 16'h0010;
    tick;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rd_gnt: got %b expected 010", gnt); end
    tick;
    checks++; if (mem_out_en !== 1'b1 || bus_drive !== 1'b0 || mem_write_en !== 1'b0) begin
      errors++; $display("FAIL rd_access: got oe %b drv %b we %b expected 1 0 0", mem_out_en, bus_drive, mem_write_en);
    end
    tick;
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL rd_ack: got %b expected 010", ack); end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h expected 5a", rdata); end
    req = 3'b000;
    tick;
    checks++; if (rdata !== 8'h5A || ack !== 3'b000) begin errors++; $display("FAIL rd_hold: got rdata %h ack %b expected 5a 000", rdata, ack); end
  endtask

  task automatic test_round_robin;
    int n_acks;
    int last_cyc;
    logic [2:0] exp_ack;
    rst_n = 1'b0;
    req = 3'b111; we = 3'b000; addr = '0;
    tick; tick;
    rst_n = 1'b1;
    n_acks = 0; last_cyc = 0; exp_ack = 3'b001;
    for (int c = 1; c <= 30 && n_acks < 6; c++) begin
      tick;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy: cycle %0d got %b expected 1", c, busy); end
      if (ack !== 3'b000) begin
        checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rr_order: got %b expected %b", ack, exp_ack); end
        checks++; if (c - last_cyc != 3) begin errors++; $display("FAIL rr_spacing: got %0d expected 3", c - last_cyc); end
        last_cyc = c;
        n_acks++;
        exp_ack = {exp_ack[1:0], exp_ack[2]};
      end
    end
    checks++; if (n_acks != 6) begin errors++; $display("FAIL rr_count: got %0d acks expected 6", n_acks); end
    req = 3'b000;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_early_drop;
    req = 3'b100; we = 3'b100; addr[32 +: 16] = 16'h0030; wdata[16 +: 8] = 8'hC3;
    tick;
    addr[32 +: 16] = 16'h0040; wdata[16 +: 8] = 8'h11;
    checks++; if (gnt !== 3'b100 || bus_out !== 16'h0030) begin
      errors++; $display("FAIL drop_addr: got gnt %b bus %h expected 100 0030", gnt, bus_out);
    end
    tick;
    req = 3'b000;
    checks++; if (bus_out !== 16'h00C3 || mem_write_en !== 1'b1) begin
      errors++; $display("FAIL drop_access: got bus %h we %b expected 00c3 1", bus_out, mem_write_en);
    end
    tick;
    checks++; if (ack !== 3'b100) begin errors++; $display("FAIL drop_ack: got %b expected 100", ack); end
    tick;
    checks++; if (mem[8'h30] !== 8'hC3 || mem[8'h40] !== 8'h00) begin
      errors++; $display("FAIL drop_mem: got [30]=%h [40]=%h expected c3 00", mem[8'h30], mem[8'h40]);
    end
  endtask

  task automatic test_single_hold;
    req = 3'b010; we = 3'b000; addr[16 +: 16] = 16'h0030;
    tick;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL hold_gnt: got %b expected 010", gnt); end
    tick;
    tick;
    checks++; if (ack !== 3'b010 || rdata !== 8'hC3) begin errors++; $display("FAIL hold_ack: got ack %b rdata %h expected 010 c3", ack, rdata); end
    tick;
    checks++; if (gnt !== 3'b000 || busy !== 1'b0 || ack !== 3'b000) begin
      errors++; $display("FAIL hold_idle: got gnt %b busy %b ack %b expected 000 0 000", gnt, busy, ack);
    end
    tick;
    checks++; if (gnt !== 3'b010 || busy !== 1'b1 || mem_mar_write_en !== 1'b1) begin
      errors++; $display("FAIL hold_regrant: got gnt %b busy %b mar %b expected 010 1 1", gnt, busy, mem_mar_write_en);
    end
    req = 3'b000;
    tick; tick;
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL hold_ack2: got %b expected 010", ack); end
    tick;
  endtask

  task automatic test_reset_mid;
    req = 3'b001; we = 3'b001; addr[0 +: 16] = 16'h0020; wdata[0 +: 8] = 8'h77;
    tick;
    tick;
    checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL rst_pre: got we %b expected 1", mem_write_en); end
    #2;
    rst_n = 1'b0;
    req = 3'b000;
    #1;
    checks++; if ({gnt, ack, busy, bus_drive} !== 8'h00 || bus_out !== 16'h0000) begin
      errors++; $display("FAIL rst_async: got gnt %b ack %b busy %b drv %b bus %h expected all 0", gnt, ack, busy, bus_drive, bus_out);
    end
    checks++; if ({mem_mar_write_en, mem_write_en, mem_out_en} !== 3'b000 || rdata !== 8'h00) begin
      errors++; $display("FAIL rst_async_en: got en %b rdata %h expected 000 00", {mem_mar_write_en, mem_write_en, mem_out_en}, rdata);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rst_no_ack: got %b expected 000", ack); end
    end
    checks++; if (mem[8'h20] !== 8'h00) begin errors++; $display("FAIL rst_mem: got %h expected 00", mem[8'h20]); end
    rst_n = 1'b1;
    req = 3'b111; we = 3'b000;
    tick;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rst_prio: got gnt %b expected 001", gnt); end
    req = 3'b000;
    for (int i = 0; i < 10 && busy === 1'b1; i++) tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_drain: got busy %b expected 0", busy); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_round_robin;
    test_early_drop;
    test_single_hold;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
